// File: rtl/alu_share_arbiter.sv
// Round-robin front end that shares one multicycle ALU between two requesters.
// One operation in flight: accept, drive ALU for ALU_LATENCY cycles, hold result until consumed.
module alu_share_arbiter #(
    parameter int DATA_WIDTH  = 32,
    parameter int ALU_LATENCY = 1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [2:0]            req0_funct3,
    input  logic [DATA_WIDTH-1:0] req0_rs1,
    input  logic [DATA_WIDTH-1:0] req0_rs2,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [2:0]            req1_funct3,
    input  logic [DATA_WIDTH-1:0] req1_rs1,
    input  logic [DATA_WIDTH-1:0] req1_rs2,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_id,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  alu_enable,
    output logic [2:0]            alu_funct3,
    output logic [DATA_WIDTH-1:0] alu_register_data_1,
    output logic [DATA_WIDTH-1:0] alu_register_data_2,
    input  logic [DATA_WIDTH-1:0] alu_register_data_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [2:0] LAT = 3'(ALU_LATENCY);

    state_t     state_q, state_d;
    logic       prio_q;
    logic [2:0] cnt_q;
    logic       grant0, grant1;
    logic       accept, capture, rsp_done;

    // prio_q names the requester that wins when both are valid
    always_comb begin
        grant0 = req0_valid && (!req1_valid || !prio_q);
        grant1 = req1_valid && (!req0_valid ||  prio_q);
    end

    always_comb begin
        state_d    = state_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        accept     = 1'b0;
        capture    = 1'b0;
        rsp_done   = 1'b0;
        case (state_q)
            IDLE: begin
                req0_ready = grant0;
                req1_ready = grant1;
                if (grant0 || grant1) begin
                    accept  = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == 3'd1) begin
                    capture = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_done = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Control: priority pointer, latency counter, enable and response valid
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prio_q     <= 1'b0;
            cnt_q      <= 3'd0;
            alu_enable <= 1'b0;
            rsp_valid  <= 1'b0;
        end else begin
            if (accept) begin
                prio_q     <= ~grant1;
                cnt_q      <= LAT;
                alu_enable <= 1'b1;
            end else if (state_q == BUSY) begin
                cnt_q <= cnt_q - 3'd1;
            end
            if (capture) begin
                alu_enable <= 1'b0;
                rsp_valid  <= 1'b1;
            end else if (rsp_done) begin
                rsp_valid  <= 1'b0;
            end
        end
    end

    // Operand and result registers; outputs must read zero after reset
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rsp_id              <= 1'b0;
            rsp_data            <= '0;
            alu_funct3          <= 3'd0;
            alu_register_data_1 <= '0;
            alu_register_data_2 <= '0;
        end else begin
            if (accept) begin
                rsp_id              <= grant1;
                alu_funct3          <= grant1 ? req1_funct3 : req0_funct3;
                alu_register_data_1 <= grant1 ? req1_rs1    : req0_rs1;
                alu_register_data_2 <= grant1 ? req1_rs2    : req0_rs2;
            end
            if (capture) rsp_data <= alu_register_data_out;
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: one instance at latency 1, one at latency 3,
// each paired with a small ADD-only ALU model that yields a valid sum only in the last enable cycle.
module tb_alu_share_arbiter;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0, rsp_ready = 1'b0;
    logic [2:0]  req0_funct3 = 3'd0, req1_funct3 = 3'd0;
    logic [31:0] req0_rs1 = '0, req0_rs2 = '0, req1_rs1 = '0, req1_rs2 = '0;

    logic        req0_ready_1, req1_ready_1, rsp_valid_1, rsp_id_1, alu_enable_1;
    logic [2:0]  alu_funct3_1;
    logic [31:0] rsp_data_1, alu_rd1_1, alu_rd2_1, alu_out_1;
    logic        req0_ready_3, req1_ready_3, rsp_valid_3, rsp_id_3, alu_enable_3;
    logic [2:0]  alu_funct3_3;
    logic [31:0] rsp_data_3, alu_rd1_3, alu_rd2_3, alu_out_3;

    logic [2:0]  en_cnt_1, en_cnt_3;
    int          n_cmp = 0;
    int          n_fail = 0;

    always #5 clock = ~clock;

    alu_share_arbiter #(.DATA_WIDTH(32), .ALU_LATENCY(1)) u_dut1 (
        .clock(clock), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready_1), .req0_funct3(req0_funct3),
        .req0_rs1(req0_rs1), .req0_rs2(req0_rs2),
        .req1_valid(req1_valid), .req1_ready(req1_ready_1), .req1_funct3(req1_funct3),
        .req1_rs1(req1_rs1), .req1_rs2(req1_rs2),
        .rsp_valid(rsp_valid_1), .rsp_ready(rsp_ready), .rsp_id(rsp_id_1), .rsp_data(rsp_data_1),
        .alu_enable(alu_enable_1), .alu_funct3(alu_funct3_1),
        .alu_register_data_1(alu_rd1_1), .alu_register_data_2(alu_rd2_1),
        .alu_register_data_out(alu_out_1)
    );

    alu_share_arbiter #(.DATA_WIDTH(32), .ALU_LATENCY(3)) u_dut3 (
        .clock(clock), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready_3), .req0_funct3(req0_funct3),
        .req0_rs1(req0_rs1), .req0_rs2(req0_rs2),
        .req1_valid(req1_valid), .req1_ready(req1_ready_3), .req1_funct3(req1_funct3),
        .req1_rs1(req1_rs1), .req1_rs2(req1_rs2),
        .rsp_valid(rsp_valid_3), .rsp_ready(rsp_ready), .rsp_id(rsp_id_3), .rsp_data(rsp_data_3),
        .alu_enable(alu_enable_3), .alu_funct3(alu_funct3_3),
        .alu_register_data_1(alu_rd1_3), .alu_register_data_2(alu_rd2_3),
        .alu_register_data_out(alu_out_3)
    );

    // ALU models: count consecutive enable cycles; the sum appears only in the final one
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            en_cnt_1 <= 3'd0;
            en_cnt_3 <= 3'd0;
        end else begin
            en_cnt_1 <= alu_enable_1 ? en_cnt_1 + 3'd1 : 3'd0;
            en_cnt_3 <= alu_enable_3 ? en_cnt_3 + 3'd1 : 3'd0;
        end
    end
    assign alu_out_1 = (alu_enable_1 && en_cnt_1 == 3'd0 && alu_funct3_1 == 3'd0) ? alu_rd1_1 + alu_rd2_1 : 32'hDEADBEEF;
    assign alu_out_3 = (alu_enable_3 && en_cnt_3 == 3'd2 && alu_funct3_3 == 3'd0) ? alu_rd1_3 + alu_rd2_3 : 32'hDEADBEEF;

    task automatic do_reset();
        reset_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
        req0_funct3 = 3'd0; req1_funct3 = 3'd0;
        req0_rs1 = '0; req0_rs2 = '0; req1_rs1 = '0; req1_rs2 = '0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_reset();
        int t;
        do_reset();
        req0_valid = 1'b1; req0_rs1 = 32'd1; req0_rs2 = 32'd2; rsp_ready = 1'b0;
        @(negedge clock);
        req0_valid = 1'b0;
        t = 0;
        while (!rsp_valid_1 && t < 10) begin @(negedge clock); t++; end
        n_cmp++; if (rsp_valid_1 !== 1'b1) begin n_fail++; $display("FAIL reset_pre_valid: got %0b want 1", rsp_valid_1); end
        n_cmp++; if (rsp_data_1 !== 32'd3) begin n_fail++; $display("FAIL reset_pre_data: got %0d want 3", rsp_data_1); end
        #2 reset_n = 1'b0;
        #1;
        n_cmp++; if (rsp_valid_1 !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %0b want 0", rsp_valid_1); end
        n_cmp++; if (rsp_id_1 !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_id: got %0b want 0", rsp_id_1); end
        n_cmp++; if (rsp_data_1 !== 32'd0) begin n_fail++; $display("FAIL reset_rsp_data: got %0h want 0", rsp_data_1); end
        n_cmp++; if (alu_enable_1 !== 1'b0) begin n_fail++; $display("FAIL reset_alu_enable: got %0b want 0", alu_enable_1); end
        n_cmp++; if (alu_funct3_1 !== 3'd0) begin n_fail++; $display("FAIL reset_alu_funct3: got %0d want 0", alu_funct3_1); end
        n_cmp++; if (alu_rd1_1 !== 32'd0) begin n_fail++; $display("FAIL reset_alu_rd1: got %0h want 0", alu_rd1_1); end
        n_cmp++; if (alu_rd2_1 !== 32'd0) begin n_fail++; $display("FAIL reset_alu_rd2: got %0h want 0", alu_rd2_1); end
        n_cmp++; if ({req0_ready_1, req1_ready_1} !== 2'b00) begin n_fail++; $display("FAIL reset_ready: got %b want 00", {req0_ready_1, req1_ready_1}); end
        @(negedge clock);
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            n_cmp++; if (rsp_valid_1 !== 1'b0) begin n_fail++; $display("FAIL reset_no_spurious[%0d]: got %0b want 0", k, rsp_valid_1); end
        end
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        n_cmp++; if ({req0_ready_1, req1_ready_1} !== 2'b10) begin n_fail++; $display("FAIL reset_prio0: got %b want 10", {req0_ready_1, req1_ready_1}); end
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        req0_valid = 1'b1; req0_funct3 = 3'd0; req0_rs1 = 32'd1; req0_rs2 = 32'd2; rsp_ready = 1'b1;
        #1;
        n_cmp++; if ({req0_ready_1, req1_ready_1} !== 2'b10) begin n_fail++; $display("FAIL single_ready: got %b want 10", {req0_ready_1, req1_ready_1}); end
        @(negedge clock);
        req0_valid = 1'b0;
        n_cmp++; if (alu_enable_1 !== 1'b1) begin n_fail++; $display("FAIL single_enable_on: got %0b want 1", alu_enable_1); end
        n_cmp++; if ({alu_rd1_1, alu_rd2_1} !== {32'd1, 32'd2}) begin n_fail++; $display("FAIL single_operands: got %0d,%0d want 1,2", alu_rd1_1, alu_rd2_1); end
        n_cmp++; if (rsp_valid_1 !== 1'b0) begin n_fail++; $display("FAIL single_valid_early: got %0b want 0", rsp_valid_1); end
        @(negedge clock);
        n_cmp++; if (alu_enable_1 !== 1'b0) begin n_fail++; $display("FAIL single_enable_off: got %0b want 0", alu_enable_1); end
        n_cmp++; if (rsp_valid_1 !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %0b want 1", rsp_valid_1); end
        n_cmp++; if (rsp_id_1 !== 1'b0) begin n_fail++; $display("FAIL single_id: got %0b want 0", rsp_id_1); end
        n_cmp++; if (rsp_data_1 !== 32'd3) begin n_fail++; $display("FAIL single_data: got %0d want 3", rsp_data_1); end
        @(negedge clock);
        n_cmp++; if (rsp_valid_1 !== 1'b0) begin n_fail++; $display("FAIL single_valid_clear: got %0b want 0", rsp_valid_1); end
    endtask

    task automatic test_fairness();
        int t;
        logic [31:0] exp_data;
        do_reset();
        req0_rs1 = 32'd1; req0_rs2 = 32'd10; req1_rs1 = 32'd1; req1_rs2 = 32'd20;
        req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            t = 0;
            while (!rsp_valid_1 && t < 10) begin @(negedge clock); t++; end
            exp_data = (i % 2 == 0) ? 32'd11 : 32'd21;
            n_cmp++; if (t !== 2) begin n_fail++; $display("FAIL fair_gap[%0d]: got %0d cycles want 2", i, t); end
            n_cmp++; if (rsp_id_1 !== 1'(i % 2)) begin n_fail++; $display("FAIL fair_id[%0d]: got %0b want %0d", i, rsp_id_1, i % 2); end
            n_cmp++; if (rsp_data_1 !== exp_data) begin n_fail++; $display("FAIL fair_data[%0d]: got %0d want %0d", i, rsp_data_1, exp_data); end
            @(negedge clock);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        int t;
        do_reset();
        req1_valid = 1'b1; req1_rs1 = 32'd4; req1_rs2 = 32'd5; rsp_ready = 1'b0;
        @(negedge clock);
        req0_valid = 1'b1; req0_rs1 = 32'd1; req0_rs2 = 32'd10;
        t = 0;
        while (!rsp_valid_1 && t < 10) begin @(negedge clock); t++; end
        for (int k = 0; k < 5; k++) begin
            n_cmp++; if (rsp_valid_1 !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d]: got %0b want 1", k, rsp_valid_1); end
            n_cmp++; if (rsp_id_1 !== 1'b1) begin n_fail++; $display("FAIL bp_id[%0d]: got %0b want 1", k, rsp_id_1); end
            n_cmp++; if (rsp_data_1 !== 32'd9) begin n_fail++; $display("FAIL bp_data[%0d]: got %0d want 9", k, rsp_data_1); end
            n_cmp++; if ({req0_ready_1, req1_ready_1} !== 2'b00) begin n_fail++; $display("FAIL bp_ready[%0d]: got %b want 00", k, {req0_ready_1, req1_ready_1}); end
            @(negedge clock);
        end
        rsp_ready = 1'b1;
        #1;
        n_cmp++; if (rsp_valid_1 !== 1'b1) begin n_fail++; $display("FAIL bp_hold_until_edge: got %0b want 1", rsp_valid_1); end
        @(negedge clock);
        n_cmp++; if (rsp_valid_1 !== 1'b0) begin n_fail++; $display("FAIL bp_handshake: got %0b want 0", rsp_valid_1); end
        n_cmp++; if ({req0_ready_1, req1_ready_1} !== 2'b10) begin n_fail++; $display("FAIL bp_next_grant: got %b want 10", {req0_ready_1, req1_ready_1}); end
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    endtask

    task automatic test_latency();
        int en_n, first;
        logic [31:0] got;
        logic        got_id;
        do_reset();
        req0_valid = 1'b1; req0_rs1 = 32'd7; req0_rs2 = 32'd5; rsp_ready = 1'b1;
        #1;
        n_cmp++; if (req0_ready_3 !== 1'b1) begin n_fail++; $display("FAIL lat_ready: got %0b want 1", req0_ready_3); end
        @(negedge clock);
        req0_valid = 1'b0;
        en_n = 0; first = 0; got = '0; got_id = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            if (alu_enable_3) en_n++;
            if (rsp_valid_3 && first == 0) begin first = k; got = rsp_data_3; got_id = rsp_id_3; end
            @(negedge clock);
        end
        n_cmp++; if (en_n !== 3) begin n_fail++; $display("FAIL lat_enable_cycles: got %0d want 3", en_n); end
        n_cmp++; if (first !== 4) begin n_fail++; $display("FAIL lat_valid_cycle: got %0d want 4", first); end
        n_cmp++; if (got !== 32'd12) begin n_fail++; $display("FAIL lat_data: got %0d want 12", got); end
        n_cmp++; if (got_id !== 1'b0) begin n_fail++; $display("FAIL lat_id: got %0b want 0", got_id); end
    endtask

    task automatic test_mid_busy_reset();
        int t;
        logic seen;
        do_reset();
        req0_valid = 1'b1; req0_rs1 = 32'd7; req0_rs2 = 32'd5; rsp_ready = 1'b1;
        @(negedge clock);
        req0_valid = 1'b0;
        @(negedge clock);
        n_cmp++; if (alu_enable_3 !== 1'b1) begin n_fail++; $display("FAIL mid_busy_enable: got %0b want 1", alu_enable_3); end
        #2 reset_n = 1'b0;
        #1;
        n_cmp++; if (alu_enable_3 !== 1'b0) begin n_fail++; $display("FAIL mid_reset_enable: got %0b want 0", alu_enable_3); end
        #1 reset_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            if (rsp_valid_3) seen = 1'b1;
        end
        n_cmp++; if (seen !== 1'b0) begin n_fail++; $display("FAIL mid_no_response: got %0b want 0", seen); end
        req0_rs1 = 32'd1; req0_rs2 = 32'd10; req1_rs1 = 32'd1; req1_rs2 = 32'd20;
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        n_cmp++; if ({req0_ready_3, req1_ready_3} !== 2'b10) begin n_fail++; $display("FAIL mid_prio: got %b want 10", {req0_ready_3, req1_ready_3}); end
        @(negedge clock);
        req0_valid = 1'b0; req1_valid = 1'b0;
        t = 0;
        while (!rsp_valid_3 && t < 10) begin @(negedge clock); t++; end
        n_cmp++; if (rsp_valid_3 !== 1'b1) begin n_fail++; $display("FAIL mid_next_valid: got %0b want 1", rsp_valid_3); end
        n_cmp++; if (rsp_id_3 !== 1'b0) begin n_fail++; $display("FAIL mid_next_id: got %0b want 0", rsp_id_3); end
        n_cmp++; if (rsp_data_3 !== 32'd11) begin n_fail++; $display("FAIL mid_next_data: got %0d want 11", rsp_data_3); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_latency();
        test_mid_busy_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
        $fatal(1, "watchdog");
    end

endmodule
